stage4: RTL and testbench
=========================

STAGE4 -- requirements
Module: stage4

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the final round number (AES-128); the valid range for `num` is 0..NR.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is asynchronous and active-low.
REQ-004 SHALL have port en, input, 1, advance/valid: when high, the inputs are consumed and the pipeline register loads.
REQ-005 SHALL have port state, input, 128, the state from the mixColumns stage (byte 0 = [127:120]).
REQ-006 SHALL have port key, input, 128, the round key for round `num`; word w0 = [127:96] and w3 = [31:0].
REQ-007 SHALL have port num, input, 4, the current round number.
REQ-008 SHALL have port done, output, 1, a registered copy of en: the outputs hold a new result.
REQ-009 SHALL have ports state_out, key_out (output, 128 each) and num_out (output, 4), the registered next-stage values.
REQ-010 SHALL have port ct, output, 128, the last completed ciphertext.
REQ-011 SHALL have port ct_valid, output, 1, a one-cycle pulse when ct updates.

Function
REQ-012 SHALL compute state_ark = state XOR key (AddRoundKey) combinationally.
REQ-013 SHALL compute the next round key combinationally, as follows:
- t = SubWord(RotWord(w3)) XOR {rcon(num+1), 24'h0};
- n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
REQ-014 SHALL use rcon(1..10) = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, from an internal table.
REQ-015 SHALL implement SubWord with four instances of the codebase's existing AES forward S-box.
REQ-016 SHALL, when en=1 and num<NR, load state_out=state_ark, key_out=next key and num_out=num+1 on the clock edge.
REQ-017 SHALL, when en=1 and num==NR, perform all of the following on the clock edge:
- load ct=state_ark and pulse ct_valid for exactly one cycle;
- load state_out=state_ark, key_out=key (unexpanded) and num_out=0.
REQ-018 SHALL, when en=1 and num>NR, load state_out=state, key_out=key and num_out=num unchanged, and SHALL NOT update ct.
REQ-019 SHALL, when en=0, hold every output register; done and ct_valid go to 0 on the next edge.
REQ-020 SHALL have a latency of exactly 1 cycle from en to done, with throughput of one block per cycle under continuous en.
REQ-021 SHALL, on back-to-back final rounds (en=1 with num==NR on consecutive cycles), update ct every cycle and hold ct_valid high for each such cycle.
REQ-022 SHALL assert done in the same cycle as ct_valid whenever ct_valid is asserted.

Reset
REQ-023 SHALL, on rst=0 (immediately, without waiting for clk), clear state_out, key_out, ct and the block counter to 0, num_out to 0, and done and ct_valid to 0.
REQ-024 SHALL discard any block in flight when reset asserts mid-operation; the first edge after rst deasserts with en=1 behaves as normal.

Configuration
REQ-025 SHALL, with STAGE4_BLOCK_COUNT_EN defined, add output blk_cnt (16 bits), incremented on each ct_valid load and wrapping from FFFF to 0000; blk_cnt SHALL reset to 0.
REQ-026 SHALL, without STAGE4_BLOCK_COUNT_EN defined, omit the blk_cnt port and counter entirely, with all other behaviour identical.

Verification
REQ-027 Round-1 key expansion: key=2b7e151628aed2a6abf7158809cf4f3c, num=0, en=1 -> next cycle key_out=a0fafe1788542cb123a339392a6c7605, num_out=1, done=1.
REQ-028 Full encryption: plaintext 3243f6a8885a308d313198a2e0370734 run through all rounds -> ct=3925841d02dc09fbdc118597196a0b32, ct_valid high for 1 cycle.
REQ-029 Final round: num=10, key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> num_out=0, key_out equals key, ct=state XOR key.
REQ-030 Stall: en=0 for 3 cycles after a load -> outputs frozen, done=0 and ct_valid=0 throughout.
REQ-031 Asynchronous reset: rst=0 mid-stream between clock edges -> all outputs 0 immediately; after release, ct stays 0 until the next final round.
REQ-032 Invalid round: num=4'hc, en=1 -> state_out=state, num_out=c, ct unchanged; with STAGE4_BLOCK_COUNT_EN, blk_cnt preset via 65535 final rounds then one more -> blk_cnt=0000.

Source files
------------

// File: rtl/stage4.sv
// ---------------------------------------------------------------------------
// stage4 -- final stage of a pipelined AES-128 encryption round.
//
// Each accepted beat performs AddRoundKey on the incoming (already
// mix-columned) state and expands the round key for the following round.
// When the incoming round number equals NR, the result of AddRoundKey is
// also the ciphertext, so it is captured in `ct` and `ct_valid` pulses.
//
// Ports:
//   clk        : single clock, all registers update on the rising edge
//   rst        : asynchronous, active-low reset
//   en         : input beat valid; inputs consumed and pipeline register loads
//   state      : 128-bit state from the mixColumns stage (byte 0 = [127:120])
//   key        : round key for round `num` (w0 = [127:96], w3 = [31:0])
//   num        : current round number (valid range 0..NR)
//   done       : registered copy of en -- outputs hold a new result
//   state_out  : registered state for the next stage
//   key_out    : registered round key for the next stage
//   num_out    : registered round number for the next stage
//   ct         : last completed ciphertext
//   ct_valid   : one-cycle pulse per ciphertext load
//   blk_cnt    : 16-bit wrapping count of ciphertext loads (optional)
//
// Configuration:
//   STAGE4_BLOCK_COUNT_EN -- when defined, adds the blk_cnt output and its
//   counter. When undefined, the port and the counter do not exist.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// aes_sbox -- AES forward substitution box, purely combinational.
//
// Ports:
//   x : input byte
//   s : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);

  // Entry i sits at bits [2047-8i -: 8], i.e. entry 0 is the leftmost byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Lower bound of entry x is 8*(255-x), which is simply {~x, 3'b000}.
  assign s = SBOX_TABLE[{~x, 3'b000} +: 8];

endmodule

module stage4 #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [3:0]   num,
  output logic         done,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic [3:0]   num_out,
  output logic [127:0] ct,
  output logic         ct_valid
`ifdef STAGE4_BLOCK_COUNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Round constants for rounds 1..10; anything else is unused and reads 0.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] c;
    c = 8'h00;
    case (round)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [127:0] state_ark;
  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [127:0] next_key;
  logic [3:0]   next_round;

  logic         is_expand;
  logic         is_final;
  logic [127:0] load_state;
  logic [127:0] load_key;
  logic [3:0]   load_num;

  assign state_ark = state ^ key;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // RotWord moves the top byte of w3 to the bottom.
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.x(rot_w3[31:24]), .s(sub_w3[31:24]));
  aes_sbox u_sbox1 (.x(rot_w3[23:16]), .s(sub_w3[23:16]));
  aes_sbox u_sbox2 (.x(rot_w3[15:8]),  .s(sub_w3[15:8]));
  aes_sbox u_sbox3 (.x(rot_w3[7:0]),   .s(sub_w3[7:0]));

  // The key being expanded belongs to round num, so the constant is for num+1.
  assign next_round = num + 4'd1;
  assign t_word     = sub_w3 ^ {rcon(next_round), 24'h000000};

  // Each new word chains off the previous new word.
  always_comb begin
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    n0 = w0 ^ t_word;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Select what the pipeline register captures. Out-of-range round numbers
  // pass the inputs through untouched so a bad beat is visible downstream.
  always_comb begin
    is_expand  = (num < LAST_ROUND);
    is_final   = (num == LAST_ROUND);
    load_state = state;
    load_key   = key;
    load_num   = num;
    if (is_expand) begin
      load_state = state_ark;
      load_key   = next_key;
      load_num   = next_round;
    end else if (is_final) begin
      load_state = state_ark;
      load_key   = key;
      load_num   = 4'd0;
    end
  end

  // done and ct_valid follow en every cycle; the data registers only move
  // on accepted beats so a stall freezes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done      <= 1'b0;
      ct_valid  <= 1'b0;
      state_out <= '0;
      key_out   <= '0;
      num_out   <= '0;
      ct        <= '0;
    end else begin
      done     <= en;
      ct_valid <= en && is_final;
      if (en) begin
        state_out <= load_state;
        key_out   <= load_key;
        num_out   <= load_num;
        if (is_final) begin
          ct <= state_ark;
        end
      end
    end
  end

`ifdef STAGE4_BLOCK_COUNT_EN
  // Counts ciphertext loads; natural 16-bit overflow provides the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt <= '0;
    end else if (en && is_final) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage4.sv
// ---------------------------------------------------------------------------
// tb_stage4 -- self-checking bench for stage4.
//
// The reference model works from the AES definition: the S-box is derived
// from GF(2^8) inversion plus the affine map, round constants by repeated
// doubling, and key expansion on 32-bit words. Outputs are checked 1 time
// unit after each rising edge.
//
// Define STAGE4_BLOCK_COUNT_EN to also exercise the blk_cnt output.
// ---------------------------------------------------------------------------
module tb_stage4;

  localparam int NR = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] state;
  logic [127:0] key;
  logic [3:0]   num;
  logic         done;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic [3:0]   num_out;
  logic [127:0] ct;
  logic         ct_valid;
`ifdef STAGE4_BLOCK_COUNT_EN
  logic [15:0]  blk_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Model of the registered outputs.
  logic         exp_done;
  logic         exp_ct_valid;
  logic [127:0] exp_state;
  logic [127:0] exp_key;
  logic [3:0]   exp_num;
  logic [127:0] exp_ct;
  logic [15:0]  exp_blk;

  logic [7:0] sbox_m [256];

  stage4 #(.NR(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .state     (state),
    .key       (key),
    .num       (num),
    .done      (done),
    .state_out (state_out),
    .key_out   (key_out),
    .num_out   (num_out),
    .ct        (ct),
    .ct_valid  (ct_valid)
`ifdef STAGE4_BLOCK_COUNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a ^= 8'h1b;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine transform.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int w = 1; w < 256; w++) begin
        if (gf_mul(8'(v), 8'(w)) == 8'h01) inv = 8'(w);
      end
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon_m(int round);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < round; i++) c = gf_mul(c, 8'h02);
    return c;
  endfunction

  // Expand the key of round (round-1) into the key of `round`.
  function automatic logic [127:0] next_key_m(logic [127:0] k, int round);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    t = {sbox_m[w[3][23:16]], sbox_m[w[3][15:8]], sbox_m[w[3][7:0]],
         sbox_m[w[3][31:24]]} ^ {rcon_m(round), 24'h000000};
    w[0] = w[0] ^ t;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // SubBytes followed by ShiftRows on a column-major state.
  function automatic logic [127:0] sub_shift(logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox_m[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
      o[127 - 8*(4*c + 0) -: 8] = gf_mul(a[0], 8'h02) ^ gf_mul(a[1], 8'h03) ^ a[2] ^ a[3];
      o[127 - 8*(4*c + 1) -: 8] = a[0] ^ gf_mul(a[1], 8'h02) ^ gf_mul(a[2], 8'h03) ^ a[3];
      o[127 - 8*(4*c + 2) -: 8] = a[0] ^ a[1] ^ gf_mul(a[2], 8'h02) ^ gf_mul(a[3], 8'h03);
      o[127 - 8*(4*c + 3) -: 8] = gf_mul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gf_mul(a[3], 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Single comparison point; every check in the bench goes through here.
  task automatic compare(string tag, logic [127:0] obs, logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one beat, advance the model by the rules of the stage, and step
  // past the next rising edge.
  task automatic applyStimulus(input logic e, input logic [3:0] n,
                               input logic [127:0] s, input logic [127:0] k);
    en    = e;
    num   = n;
    state = s;
    key   = k;
    exp_done     = e;
    exp_ct_valid = 1'b0;
    if (e) begin
      if (int'(n) < NR) begin
        exp_state = s ^ k;
        exp_key   = next_key_m(k, int'(n) + 1);
        exp_num   = n + 4'd1;
      end else if (int'(n) == NR) begin
        exp_state    = s ^ k;
        exp_key      = k;
        exp_num      = 4'd0;
        exp_ct       = s ^ k;
        exp_ct_valid = 1'b1;
        exp_blk      = exp_blk + 16'd1;
      end else begin
        exp_state = s;
        exp_key   = k;
        exp_num   = n;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_done     = 1'b0;
    exp_ct_valid = 1'b0;
    exp_state    = '0;
    exp_key      = '0;
    exp_num      = '0;
    exp_ct       = '0;
    exp_blk      = '0;
  endtask

  // Compare every output against the model.
  task automatic checkOutput(string tag);
    compare({tag, ".done"},      128'(done),      128'(exp_done));
    compare({tag, ".ct_valid"},  128'(ct_valid),  128'(exp_ct_valid));
    compare({tag, ".state_out"}, state_out,       exp_state);
    compare({tag, ".key_out"},   key_out,         exp_key);
    compare({tag, ".num_out"},   128'(num_out),   128'(exp_num));
    compare({tag, ".ct"},        ct,              exp_ct);
`ifdef STAGE4_BLOCK_COUNT_EN
    compare({tag, ".blk_cnt"},   128'(blk_cnt),   128'(exp_blk));
`endif
  endtask

  // Directed steps followed by a randomized run.
  initial begin
    logic [127:0] ms;
    logic [127:0] mk;
    logic [127:0] s_in;
    logic [127:0] k_in;

    rst   = 1'b0;
    en    = 1'b0;
    num   = '0;
    state = '0;
    key   = '0;
    model_reset();
    build_sbox();

    #12;
    checkOutput("reset");
    rst = 1'b1;

    // Full FIPS-197 encryption; round 0 also covers the first key expansion.
    applyStimulus(1'b1, 4'd0, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("enc_r0");
    compare("round1_key", key_out, 128'ha0fafe1788542cb123a339392a6c7605);
    ms = exp_state;
    mk = exp_key;
    for (int r = 1; r <= NR; r++) begin
      s_in = (r < NR) ? mix(sub_shift(ms)) : sub_shift(ms);
      applyStimulus(1'b1, 4'(r), s_in, mk);
      checkOutput($sformatf("enc_r%0d", r));
      ms = exp_state;
      mk = exp_key;
    end
    compare("enc_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);
    compare("enc_ct_valid", 128'(ct_valid), 128'd1);
    applyStimulus(1'b0, 4'd0, rand128(), rand128());
    checkOutput("enc_after");

    // Final round with the last FIPS-197 round key.
    s_in = rand128();
    applyStimulus(1'b1, 4'd10, s_in, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    checkOutput("final");
    compare("final_key", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    compare("final_ct", ct, s_in ^ 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Load then stall for three cycles with junk on the inputs.
    applyStimulus(1'b1, 4'd3, rand128(), rand128());
    checkOutput("stall_load");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'($urandom_range(0, 15)), rand128(), rand128());
      checkOutput($sformatf("stall%0d", i));
    end

    // Back-to-back final rounds keep ct_valid high.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd10, rand128(), rand128());
      checkOutput($sformatf("b2b%0d", i));
    end
    applyStimulus(1'b0, 4'd10, rand128(), rand128());
    checkOutput("b2b_end");

    // Out-of-range round number passes through, ct untouched.
    applyStimulus(1'b1, 4'hc, rand128(), rand128());
    checkOutput("invalid_c");
    applyStimulus(1'b1, 4'hf, rand128(), rand128());
    checkOutput("invalid_f");

    // Asynchronous reset between edges, then resume without a final round.
    applyStimulus(1'b1, 4'd10, rand128(), rand128());
    checkOutput("pre_rst");
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    checkOutput("async_rst");
    @(posedge clk);
    #1;
    checkOutput("rst_held");
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 9)), rand128(), rand128());
      checkOutput($sformatf("post_rst%0d", i));
    end

    // Randomized traffic, final rounds made reasonably frequent.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] n;
      n = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 3) != 0, n, rand128(), rand128());
      checkOutput($sformatf("rand%0d", i));
    end

`ifdef STAGE4_BLOCK_COUNT_EN
    // Drive the counter to its top value, then one more final round wraps it.
    for (int i = 0; i < 65536 && exp_blk != 16'hffff; i++) begin
      applyStimulus(1'b1, 4'd10, rand128(), rand128());
    end
    checkOutput("cnt_top");
    compare("cnt_ffff", 128'(blk_cnt), 128'h0ffff);
    applyStimulus(1'b1, 4'd10, rand128(), rand128());
    checkOutput("cnt_wrap");
    compare("cnt_zero", 128'(blk_cnt), 128'h0);
`endif

    $display("[TB] directed and random sequences complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
